// File: rtl/pipelined_ctrl_unit_if.sv
// pipelined_ctrl_unit_if
//   Handshake and control-bundle bus between fetch/pipeline and the
//   registered control unit.
//   master : drives instr_valid, instr, ext_stall, ex_flush, resume;
//            observes instr_ready, hazard_stall, halted, ctrl_pipe
//   slave  : the control unit (mirror of master)
interface pipelined_ctrl_unit_if #(
    parameter int PIPE_DEPTH = 3,
    parameter int ENTRY_W    = 23
);
    logic                          instr_valid;
    logic [31:0]                   instr;
    logic                          instr_ready;
    logic                          ext_stall;
    logic                          ex_flush;
    logic                          resume;
    logic                          hazard_stall;
    logic                          halted;
    logic [PIPE_DEPTH*ENTRY_W-1:0] ctrl_pipe;

    modport master (
        output instr_valid, instr, ext_stall, ex_flush, resume,
        input  instr_ready, hazard_stall, halted, ctrl_pipe
    );

    modport slave (
        input  instr_valid, instr, ext_stall, ex_flush, resume,
        output instr_ready, hazard_stall, halted, ctrl_pipe
    );
endinterface

// File: rtl/pipelined_ctrl_unit.sv
// pipelined_ctrl_unit
//   Decodes the RV32I instruction in ID into an 18-bit control bundle plus
//   rd, and shifts it through PIPE_DEPTH registered stages (stage 0 = EX).
//   Adds a valid/ready fetch handshake, load-use stall, branch flush and an
//   ecall drain/halt FSM.
//   Ports: clk (rising edge), rst (async, active-high),
//          bus : pipelined_ctrl_unit_if.slave (instr_valid/instr/instr_ready,
//                ext_stall, ex_flush, resume, hazard_stall, halted, ctrl_pipe)
//   Optional feature macro: BRANCH_EXT_EN (decode bge/bltu/bgeu).
module pipelined_ctrl_unit #(
    parameter int PIPE_DEPTH = 3,
    parameter int ENTRY_W    = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_ctrl_unit_if.slave bus
);
    typedef struct packed {
        logic [4:0] rd;
        logic illegal, bgeu, bltu, bge, blt, sb, sltiu, jalr, jal, bne, beq;
        logic s_type, ecall, reg_write, alu_src, mem_write, mem_to_reg, valid;
    } entry_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    entry_t     stage_q [PIPE_DEPTH];
    state_t     state_q;
    logic [1:0] cnt_q;
    logic       halted_q;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    entry_t     dec, s0, s0_d;
    logic       ok, use_rs1, use_rs2, hazard, advance, ready;
    logic [4:0] rs1, rs2;

    assign opc = bus.instr[6:0];
    assign f3  = bus.instr[14:12];
    assign f7  = bus.instr[31:25];

    // Decoder: a template is filled per opcode, then ok decides whether it
    // stands or collapses to valid|illegal with no source registers.
    always_comb begin
        dec     = '0;
        ok      = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        rs1     = bus.instr[19:15];
        rs2     = bus.instr[24:20];
        case (opc)
            OP_R: begin
                // sll and xor are not part of this core's R subset
                ok = (f7 == 7'b0000000 && f3 != 3'b001 && f3 != 3'b100) ||
                     (f7 == 7'b0100000 && f3 == 3'b000);
                dec.reg_write = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_I: begin
                case (f3)
                    3'b001:  ok = (f7 == 7'b0000000);
                    3'b101:  ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    default: ok = 1'b1;
                endcase
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.sltiu     = (f3 == 3'b011);
                use_rs1 = 1'b1;
            end
            OP_LOAD: begin
                ok = (f3 == 3'b010);
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_STORE: begin
                ok = (f3 == 3'b010) || (f3 == 3'b000);
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.s_type    = 1'b1;
                dec.sb        = (f3 == 3'b000);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_BR: begin
                case (f3)
                    3'b000:  begin ok = 1'b1; dec.beq  = 1'b1; end
                    3'b001:  begin ok = 1'b1; dec.bne  = 1'b1; end
                    3'b100:  begin ok = 1'b1; dec.blt  = 1'b1; end
`ifdef BRANCH_EXT_EN
                    3'b101:  begin ok = 1'b1; dec.bge  = 1'b1; end
                    3'b110:  begin ok = 1'b1; dec.bltu = 1'b1; end
                    3'b111:  begin ok = 1'b1; dec.bgeu = 1'b1; end
`endif
                    default: ok = 1'b0;
                endcase
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_JAL: begin
                ok = 1'b1;
                dec.reg_write = 1'b1;
                dec.jal       = 1'b1;
            end
            OP_JALR: begin
                ok = (f3 == 3'b000);
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.jalr      = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_SYS: begin
                // Only the exact ecall word; ebreak/csr* are illegal here.
                ok = (bus.instr[31:7] == 25'd0);
                dec.ecall = 1'b1;
                rs1 = 5'd17;
                rs2 = 5'd10;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (ok) begin
            dec.valid = 1'b1;
            dec.rd    = dec.reg_write ? bus.instr[11:7] : 5'd0;
        end else begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end
    end

    assign s0     = stage_q[0];
    assign hazard = bus.instr_valid & s0.valid & s0.mem_to_reg & (s0.rd != 5'd0) &
                    ((use_rs1 & (rs1 == s0.rd)) | (use_rs2 & (rs2 == s0.rd)));

    // Edge control: HALTED freezes the stages just like ext_stall.
    always_comb begin
        advance = 1'b0;
        ready   = 1'b0;
        s0_d    = '0;
        if (!bus.ext_stall && state_q != HALTED) begin
            advance = 1'b1;
            if (bus.ex_flush) begin
                ready = 1'b1;
            end else if (state_q == RUN && !hazard) begin
                ready = bus.instr_valid;
                if (bus.instr_valid) s0_d = dec;
            end
        end
    end

    assign bus.instr_ready  = ready & ~rst;
    assign bus.hazard_stall = hazard;
    assign bus.halted       = halted_q;

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_out
        assign bus.ctrl_pipe[g*ENTRY_W +: ENTRY_W] = stage_q[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) stage_q[k] <= '0;
            state_q  <= RUN;
            cnt_q    <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            if (advance) begin
                stage_q[0] <= s0_d;
                for (int k = 1; k < PIPE_DEPTH; k++) stage_q[k] <= stage_q[k-1];
            end
            if (!bus.ext_stall) begin
                case (state_q)
                    RUN: if (s0_d.ecall) begin
                        cnt_q <= 2'd0;
                        if (PIPE_DEPTH == 1) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        // ecall moves from stage cnt_q to cnt_q+1 on this edge
                        cnt_q <= cnt_q + 2'd1;
                        if (int'(cnt_q) + 2 == PIPE_DEPTH) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end
                    end
                    HALTED: if (bus.resume) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end
endmodule

// File: doc/pipelined_ctrl_unit.md
# pipelined_ctrl_unit

Registered, parametrised successor to the combinational control decoder for the pipelined RV32I core. It decodes the instruction in ID into an 18-bit control bundle plus destination register, and carries that payload down a `PIPE_DEPTH`-stage shift register (EX, MEM, WB, …). It also provides:
- a valid/ready instruction handshake toward fetch;
- load-use hazard stalls;
- branch flush;
- an ecall drain/halt state machine.

## Interface
Parameters:
- `PIPE_DEPTH`, default 3: number of registered payload stages; legal range 1..4. Stage 0 is EX.
- `ENTRY_W`, default 23: payload width, fixed as 18-bit bundle + 5-bit rd. Must not be overridden.

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  `instr` holds a fetched instruction.
- `instr`  in  32  instruction in ID.
- `instr_ready`  out  1  instruction consumed on this edge.
- `ext_stall`  in  1  freeze all state.
- `ex_flush`  in  1  branch/jump taken in EX; discard the ID instruction.
- `resume`  in  1  leave HALTED.
- `hazard_stall`  out  1  load-use stall active, combinational.
- `halted`  out  1  FSM is in HALTED.
- `ctrl_pipe`  out  `PIPE_DEPTH*ENTRY_W`  stage k occupies `[k*ENTRY_W +: ENTRY_W]`.

Entry layout:
- [22:18] rd
- bits 0..17: valid, mem_to_reg, mem_write, alu_src, reg_write, ecall, s_type, beq, bne, jal, jalr, sltiu, sb, blt, bge, bltu, bgeu, illegal

## Operation
Decode, using full 7-bit opcode, funct3 and funct7. Any unlisted encoding produces `valid|illegal` with rd=0.
- R-type (add, sub, and, or, slt, sltu, srl), exact funct7: reg_write.
- I-ALU (addi, andi, ori, xori, slti, slli, srli, srai): alu_src, reg_write. Shift instructions check funct7.
- sltiu: alu_src, reg_write, sltiu.
- lw: mem_to_reg, alu_src, reg_write.
- sw: mem_write, alu_src, s_type.
- sb: as sw, plus sb.
- beq, bne, blt: the matching bit only.
- jal: reg_write, jal.
- jalr: alu_src, reg_write, jalr.
- ecall: ecall only.
- valid=1 on every decoded entry. rd = instr[11:7] if reg_write, else 0.

Hazard:
- Source registers: rs1 for all types except jal. rs2 for R, S and B types. ecall reads x17 (rs1) and x10 (rs2).
- `hazard_stall` = instr_valid & stage0.valid & stage0.mem_to_reg & stage0.rd≠0 & (stage0.rd matches a used source register).

Per edge, with priority top to bottom:
- `ext_stall`=1: hold all stages and the FSM. `instr_ready`=0.
- `ex_flush`=1: stage0←bubble (all zero), stages shift, `instr_ready`=1 (instruction discarded).
- FSM not RUN, or `hazard_stall`: stage0←bubble, shift, `instr_ready`=0.
- Otherwise: stage0←decoded entry if `instr_valid` else bubble, shift, `instr_ready`=`instr_valid`.

FSM:
- RUN → DRAIN when an ecall is loaded into stage0. Counter←0.
- DRAIN: counter increments per advancing edge. When the ecall lands in stage `PIPE_DEPTH-1`, go to HALTED. With `PIPE_DEPTH`=1, go straight from RUN to HALTED on the load edge.
- HALTED: all stages frozen. `resume`=1 → RUN on the next edge. `resume` is ignored in RUN and DRAIN.
- Flush on the edge an ecall sits in ID: the ecall is discarded and no DRAIN occurs.

## Timing
- Reset: all stages 0, FSM RUN, counter 0, `halted`=0, `instr_ready`=0.
- Reset mid-drain or while halted returns to RUN with an empty pipe.
- Decode-to-stage-k latency is k+1 cycles. `instr_ready` and `hazard_stall` are combinational from the current inputs and state.
- A load-use stall lasts exactly 1 cycle when not externally stalled. The dependent instruction is accepted on the following edge.
- The `halted` output rises exactly `PIPE_DEPTH` advancing edges after the ecall is accepted.

## Configuration
- `BRANCH_EXT_EN` defined: additionally decode bge (funct3 101), bltu (110) and bgeu (111) on opcode 1100011, each setting only its own bit. These instructions use rs1 and rs2 for hazard detection.
- Not defined: those encodings decode as illegal, and bits bge, bltu and bgeu are tied to 0.

## Test plan
- Reset, then 0x002081B3 (add x3,x1,x2) valid for one cycle → `instr_ready`=1; stage0 = 0xC0011 after 1 edge; stage2 holds the same entry after 3 edges.
- 0x0000A283 (lw x5) then 0x00028333 (add x6,x5,x0) → `hazard_stall`=1 for 1 cycle, bubble in stage0, add accepted on the next edge.
- add in ID with `ex_flush`=1 → `instr_ready`=1, stage0 = 0.
- 0x00000073 (ecall), `PIPE_DEPTH`=3 → `instr_ready`=0 during drain; `halted`=1 after 3 edges; stays halted until `resume`, back in RUN 1 edge later.
- 0x0020D063 (bge) → with `BRANCH_EXT_EN`: entry 0x04001; without: 0x20001 (illegal).
- `ext_stall`=1 for 4 cycles mid-stream → all stages unchanged, `instr_ready`=0; assert `rst` during DRAIN → immediate all-zero pipe, `halted`=0.
